// File: rtl/nios_sys_cache_port_arbiter.sv
// Two-master round-robin arbiter for port 2 of the 512x32 cache RAM.
// Supports single and incrementing-burst reads and writes with Avalon-style waitrequest/readdatavalid.
module nios_sys_cache_port_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                m0_req,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [BC_W-1:0]     m0_burstcount,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_rvalid,

    input  logic                m1_req,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [BC_W-1:0]     m1_burstcount,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_rvalid,

    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata,

    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int BE_W = DATA_W / 8;

    // Handshake: a master's command or write beat is accepted in any cycle where its req is high
    // and its waitrequest is low; read words return one per cycle, flagged by that master's rvalid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic [ADDR_W-1:0]   base;
    logic [BC_W-1:0]     beat;
    logic [BC_W-1:0]     total;
    logic                rvalid_q;
    logic                rtag;
    logic [ADDR_W-1:0]   addr_hold;
    logic                busy_q;

    logic                win;
    logic                grant;
    logic                w_write;
    logic [ADDR_W-1:0]   w_addr;
    logic [BC_W-1:0]     w_total;
    logic [DATA_W-1:0]   w_wdata;
    logic [BE_W-1:0]     w_be;
    logic                o_req;
    logic                o_write;
    logic [DATA_W-1:0]   o_wdata;
    logic [BE_W-1:0]     o_be;
    logic [ADDR_W-1:0]   beat_addr;
    logic                issue;
    logic                iss_write;
    logic [ADDR_W-1:0]   iss_addr;
    logic [DATA_W-1:0]   iss_wdata;
    logic [BE_W-1:0]     iss_be;
    logic                iss_tag;
    logic                acc0;
    logic                acc1;

    // Zero means a single beat; anything above MAX_BURST is clipped.
    function automatic logic [BC_W-1:0] clamp_count(input logic [BC_W-1:0] bc);
        if (bc == '0) return BC_W'(1);
        if (bc > BC_W'(MAX_BURST)) return BC_W'(MAX_BURST);
        return bc;
    endfunction

    always_comb begin
        win = 1'b0;
        if (m0_req && m1_req) win = ~last_grant;
        else if (m1_req)      win = 1'b1;
        grant = (state == IDLE) && (m0_req || m1_req) && reset_n;

        w_write = win ? m1_write : m0_write;
        w_addr  = win ? m1_addr  : m0_addr;
        w_total = clamp_count(win ? m1_burstcount : m0_burstcount);
        w_wdata = win ? m1_wdata : m0_wdata;
        w_be    = win ? m1_be    : m0_be;

        o_req   = owner ? m1_req   : m0_req;
        o_write = owner ? m1_write : m0_write;
        o_wdata = owner ? m1_wdata : m0_wdata;
        o_be    = owner ? m1_be    : m0_be;

        beat_addr = base + ADDR_W'(beat);

        issue     = 1'b0;
        iss_write = 1'b0;
        iss_addr  = addr_hold;
        iss_wdata = o_wdata;
        iss_be    = o_be;
        iss_tag   = owner;
        acc0      = 1'b0;
        acc1      = 1'b0;

        case (state)
            IDLE: begin
                // Beat 0 goes straight through to the RAM in the grant cycle.
                if (grant) begin
                    issue     = 1'b1;
                    iss_write = w_write;
                    iss_addr  = w_addr;
                    iss_wdata = w_wdata;
                    iss_be    = w_be;
                    iss_tag   = win;
                    acc0      = ~win;
                    acc1      = win;
                end
            end
            RD: begin
                issue    = 1'b1;
                iss_addr = beat_addr;
            end
            WR: begin
                if (o_req && o_write) begin
                    issue     = 1'b1;
                    iss_write = 1'b1;
                    iss_addr  = beat_addr;
                    acc0      = ~owner;
                    acc1      = owner;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            base       <= '0;
            beat       <= '0;
            total      <= '0;
            rvalid_q   <= 1'b0;
            rtag       <= 1'b0;
            addr_hold  <= '0;
            busy_q     <= 1'b0;
        end else begin
            rvalid_q <= issue & ~iss_write;
            rtag     <= iss_tag;
            if (issue) addr_hold <= iss_addr;

            case (state)
                IDLE: begin
                    if (grant) begin
                        owner      <= win;
                        last_grant <= win;
                        base       <= w_addr;
                        total      <= w_total;
                        beat       <= BC_W'(1);
                        if (w_total != BC_W'(1)) begin
                            state  <= w_write ? WR : RD;
                            busy_q <= 1'b1;
                        end
                    end
                end
                RD, WR: begin
                    // Write bursts only advance on beats the owner actually presents.
                    if (issue) begin
                        if (beat == total - BC_W'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            beat <= beat + BC_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign m0_waitrequest = ~(acc0 & reset_n);
    assign m1_waitrequest = ~(acc1 & reset_n);
    assign m0_rvalid      = rvalid_q & ~rtag;
    assign m1_rvalid      = rvalid_q & rtag;
    assign m0_rdata       = ram_readdata;
    assign m1_rdata       = ram_readdata;

    assign ram_chipselect = issue;
    assign ram_write      = iss_write;
    assign ram_address    = iss_addr;
    assign ram_writedata  = iss_wdata;
    assign ram_byteenable = iss_be;
    assign ram_clken      = 1'b1;

    assign busy      = busy_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_nios_sys_cache_port_arbiter.sv
// Directed bench for nios_sys_cache_port_arbiter with a behavioural port-2 RAM
// (registered address, unregistered q_b, byte-enabled writes).
module tb_nios_sys_cache_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int MAX_BURST = 16;
    localparam int BC_W = 5;
    localparam int BE_W = 4;

    logic clk;
    logic reset_n;
    logic m0_req, m0_write, m1_req, m1_write;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [BC_W-1:0] m0_burstcount, m1_burstcount;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [BE_W-1:0] m0_be, m1_be;
    logic m0_waitrequest, m1_waitrequest, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic ram_chipselect, ram_write, ram_clken;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_writedata, ram_readdata;
    logic [BE_W-1:0] ram_byteenable;
    logic busy;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    nios_sys_cache_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BC_W(BC_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_burstcount(m0_burstcount),
        .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_waitrequest(m0_waitrequest),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_burstcount(m1_burstcount),
        .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_waitrequest(m1_waitrequest),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_address(ram_address),
        .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable), .ram_clken(ram_clken),
        .ram_readdata(ram_readdata), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:511];
    logic [ADDR_W-1:0] ram_areg = '0;
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write)
                for (int b = 0; b < BE_W; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            ram_areg <= ram_address;
        end
    end
    assign ram_readdata = mem[ram_areg];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_burstcount = 5'd1; m0_wdata = '0; m0_be = 4'hF;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_burstcount = 5'd1; m1_wdata = '0; m1_be = 4'hF;
    endtask

    task automatic test_reset();
        reset_n = 0;
        m0_req = 1; m1_req = 1;
        @(negedge clk); #1;
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait: got %b want 1", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m1_wait: got %b want 1", m1_waitrequest); end
        checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", ram_chipselect); end
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b want 0", ram_write); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        checks++; if (ram_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b want 1", ram_clken); end
        @(negedge clk);
        idle_inputs();
        reset_n = 1;
    endtask

    task automatic test_single();
        @(negedge clk);
        m0_req = 1; m0_write = 1; m0_addr = 9'd5; m0_burstcount = 5'd1; m0_wdata = 32'hDEADBEEF; m0_be = 4'hF;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sw_m0_wait: got %b want 0", m0_waitrequest); end
        checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL sw_m1_wait: got %b want 1", m1_waitrequest); end
        checks++; if ({ram_chipselect, ram_write} !== 2'b11) begin errors++; $display("FAIL sw_strobes: got %b want 11", {ram_chipselect, ram_write}); end
        checks++; if (ram_address !== 9'd5) begin errors++; $display("FAIL sw_addr: got %0d want 5", ram_address); end
        @(negedge clk);
        m0_write = 0;
        #1;
        checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h want deadbeef", mem[5]); end
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL sr_m0_wait: got %b want 0", m0_waitrequest); end
        checks++; if ({ram_chipselect, ram_write} !== 2'b10) begin errors++; $display("FAIL sr_strobes: got %b want 10", {ram_chipselect, ram_write}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_busy: got %b want 0", busy); end
        @(negedge clk);
        m0_write = 1; m0_wdata = 32'h12345678; m0_be = 4'b0011;
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL sr_m0_rvalid: got %b want 1", m0_rvalid); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata: got %h want deadbeef", m0_rdata); end
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL sr_m1_rvalid: got %b want 0", m1_rvalid); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (mem[5] !== 32'hDEAD5678) begin errors++; $display("FAIL be_mem: got %h want dead5678", mem[5]); end
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL be_no_rvalid: got %b want 0", m0_rvalid); end
        checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs: got %b want 0", ram_chipselect); end
        checks++; if (ram_address !== 9'd5) begin errors++; $display("FAIL idle_addr_hold: got %0d want 5", ram_address); end
    endtask

    task automatic test_round_robin();
        int prev;
        int exp_w;
        mem[10] = 32'hA0A0A0A0;
        mem[20] = 32'hB0B0B0B0;
        @(negedge clk); reset_n = 0;
        @(negedge clk); reset_n = 1;
        m0_req = 1; m0_write = 0; m0_addr = 9'd10;
        m1_req = 1; m1_write = 0; m1_addr = 9'd20;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_w = k % 2;
            checks++; if (m0_waitrequest !== (exp_w != 0)) begin errors++; $display("FAIL rr_m0_wait[%0d]: got %b want %b", k, m0_waitrequest, exp_w != 0); end
            checks++; if (m1_waitrequest !== (exp_w != 1)) begin errors++; $display("FAIL rr_m1_wait[%0d]: got %b want %b", k, m1_waitrequest, exp_w != 1); end
            checks++; if (ram_address !== (exp_w == 1 ? 9'd20 : 9'd10)) begin errors++; $display("FAIL rr_addr[%0d]: got %0d", k, ram_address); end
            if (k > 0) begin
                checks++; if (m0_rvalid !== (prev == 0)) begin errors++; $display("FAIL rr_m0_rvalid[%0d]: got %b want %b", k, m0_rvalid, prev == 0); end
                checks++; if (m1_rvalid !== (prev == 1)) begin errors++; $display("FAIL rr_m1_rvalid[%0d]: got %b want %b", k, m1_rvalid, prev == 1); end
                checks++; if (m1_rdata !== (prev == 1 ? 32'hB0B0B0B0 : 32'hA0A0A0A0)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h", k, m1_rdata); end
            end
            prev = exp_w;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin errors++; $display("FAIL rr_last_rvalid: got %b want 01", {m0_rvalid, m1_rvalid}); end
    endtask

    task automatic test_read_burst_wrap();
        logic [ADDR_W-1:0] exp_addr [4];
        logic [DATA_W-1:0] exp_data [4];
        exp_addr = '{9'd510, 9'd511, 9'd0, 9'd1};
        exp_data = '{32'h5100_0510, 32'h5100_0511, 32'h5100_0000, 32'h5100_0001};
        for (int i = 0; i < 4; i++) mem[exp_addr[i]] = exp_data[i];
        @(negedge clk);
        m1_req = 1; m1_write = 0; m1_addr = 9'd510; m1_burstcount = 5'd4;
        #1;
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rb_m1_wait: got %b want 0", m1_waitrequest); end
        checks++; if (ram_address !== 9'd510) begin errors++; $display("FAIL rb_addr[0]: got %0d want 510", ram_address); end
        @(negedge clk);
        m1_req = 0;
        m0_req = 1; m0_write = 0; m0_addr = 9'd0;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++; if (ram_address !== exp_addr[k]) begin errors++; $display("FAIL rb_addr[%0d]: got %0d want %0d", k, ram_address, exp_addr[k]); end
            checks++; if (ram_chipselect !== 1'b1) begin errors++; $display("FAIL rb_cs[%0d]: got %b want 1", k, ram_chipselect); end
            checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL rb_wait[%0d]: got %b want 11", k, {m0_waitrequest, m1_waitrequest}); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_busy[%0d]: got %b want 1", k, busy); end
            checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin errors++; $display("FAIL rb_rvalid[%0d]: got %b want 01", k, {m0_rvalid, m1_rvalid}); end
            checks++; if (m1_rdata !== exp_data[k-1]) begin errors++; $display("FAIL rb_rdata[%0d]: got %h want %h", k, m1_rdata, exp_data[k-1]); end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rb_busy_end: got %b want 0", busy); end
        checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rb_cs_end: got %b want 0", ram_chipselect); end
        checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL rb_rvalid_last: got %b want 1", m1_rvalid); end
        checks++; if (m1_rdata !== exp_data[3]) begin errors++; $display("FAIL rb_rdata_last: got %h want %h", m1_rdata, exp_data[3]); end
        @(negedge clk); #1;
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL rb_rvalid_after: got %b want 0", m1_rvalid); end
    endtask

    task automatic test_write_burst_stall();
        @(negedge clk);
        m0_req = 1; m0_write = 1; m0_addr = 9'd100; m0_burstcount = 5'd3; m0_wdata = 32'h11111111; m0_be = 4'hF;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wb_wait0: got %b want 0", m0_waitrequest); end
        checks++; if (ram_address !== 9'd100) begin errors++; $display("FAIL wb_addr0: got %0d want 100", ram_address); end
        @(negedge clk);
        m0_wdata = 32'h22222222;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wb_wait1: got %b want 0", m0_waitrequest); end
        checks++; if (ram_address !== 9'd101) begin errors++; $display("FAIL wb_addr1: got %0d want 101", ram_address); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL wb_state: got %0d want 2", dbg_state); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m0_req = 0;
            m1_req = 1; m1_write = 0; m1_addr = 9'd0;
            #1;
            checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL wb_stall_cs[%0d]: got %b want 0", k, ram_chipselect); end
            checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wb_stall_m1[%0d]: got %b want 1", k, m1_waitrequest); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wb_stall_busy[%0d]: got %b want 1", k, busy); end
        end
        @(negedge clk);
        m1_req = 0;
        m0_req = 1; m0_wdata = 32'h33333333;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL wb_wait2: got %b want 0", m0_waitrequest); end
        checks++; if ({ram_chipselect, ram_write} !== 2'b11) begin errors++; $display("FAIL wb_strobes2: got %b want 11", {ram_chipselect, ram_write}); end
        checks++; if (ram_address !== 9'd102) begin errors++; $display("FAIL wb_addr2: got %0d want 102", ram_address); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wb_busy_end: got %b want 0", busy); end
        checks++; if (mem[100] !== 32'h11111111) begin errors++; $display("FAIL wb_mem100: got %h", mem[100]); end
        checks++; if (mem[101] !== 32'h22222222) begin errors++; $display("FAIL wb_mem101: got %h", mem[101]); end
        checks++; if (mem[102] !== 32'h33333333) begin errors++; $display("FAIL wb_mem102: got %h", mem[102]); end
    endtask

    task automatic test_burstcount_bounds();
        int cnt;
        int rcnt;
        @(negedge clk);
        m1_req = 1; m1_write = 0; m1_addr = 9'd300; m1_burstcount = 5'd0;
        cnt = 0; rcnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ram_chipselect) cnt++;
            if (m1_rvalid) rcnt++;
            @(negedge clk);
            m1_req = 0;
        end
        checks++; if (cnt !== 1) begin errors++; $display("FAIL bc0_beats: got %0d want 1", cnt); end
        checks++; if (rcnt !== 1) begin errors++; $display("FAIL bc0_rvalids: got %0d want 1", rcnt); end
        m0_req = 1; m0_write = 0; m0_addr = 9'd400; m0_burstcount = 5'd31;
        cnt = 0; rcnt = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (ram_chipselect) cnt++;
            if (m0_rvalid) rcnt++;
            @(negedge clk);
            m0_req = 0;
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL bc31_beats: got %0d want 16", cnt); end
        checks++; if (rcnt !== 16) begin errors++; $display("FAIL bc31_rvalids: got %0d want 16", rcnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bc31_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        m0_req = 1; m0_write = 0; m0_addr = 9'd200; m0_burstcount = 5'd8;
        #1;
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rm_wait0: got %b want 0", m0_waitrequest); end
        @(negedge clk);
        m0_req = 0;
        #1;
        checks++; if (ram_address !== 9'd201) begin errors++; $display("FAIL rm_addr1: got %0d want 201", ram_address); end
        reset_n = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy); end
        checks++; if (ram_chipselect !== 1'b0) begin errors++; $display("FAIL rm_cs: got %b want 0", ram_chipselect); end
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid_now: got %b want 0", m0_rvalid); end
        m0_req = 1; m0_write = 0; m0_addr = 9'd10; m0_burstcount = 5'd1;
        m1_req = 1; m1_write = 0; m1_addr = 9'd20; m1_burstcount = 5'd1;
        #1;
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin errors++; $display("FAIL rm_wait_rst: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rm_rvalid_rst[%0d]: got %b want 00", k, {m0_rvalid, m1_rvalid}); end
        end
        @(negedge clk);
        reset_n = 1;
        #1;
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL rm_first_tie: got %b want 01", {m0_waitrequest, m1_waitrequest}); end
        checks++; if (ram_address !== 9'd10) begin errors++; $display("FAIL rm_first_addr: got %0d want 10", ram_address); end
        @(negedge clk); #1;
        checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin errors++; $display("FAIL rm_second_tie: got %b want 10", {m0_waitrequest, m1_waitrequest}); end
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA0A0A0A0) begin errors++; $display("FAIL rm_m0_read: got %b/%h want 1/a0a0a0a0", m0_rvalid, m0_rdata); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB0B0B0B0) begin errors++; $display("FAIL rm_m1_read: got %b/%h want 1/b0b0b0b0", m1_rvalid, m1_rdata); end
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_read_burst_wrap();
        test_write_burst_stall();
        test_burstcount_bounds();
        test_reset_midburst();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
